// File: rtl/pixel_mem_pkg.sv
// rtl/pixel_mem_pkg.sv - shared types and constants for the Avalon-MM pixel memory
//
// Purpose : FSM state encoding, default wait-state counts, LFSR constants and
//           the error-counter ceiling used by avs_pixel_memory.
// Ports   : none (package).
// Options : PIXEL_MEM_RANDOM_WAIT_EN (consumed by avs_pixel_memory) uses
//           LFSR_SEED / LFSR_TAPS / lfsr_next.

package pixel_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam int DEF_READ_WAIT  = 2;
  localparam int DEF_WRITE_WAIT = 1;

  // Width of the wait-state down-counter.
  localparam int CNT_W = 16;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  // One step of the Fibonacci LFSR: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pixel_mem_ram.sv
// rtl/pixel_mem_ram.sv - single-port synchronous RAM with registered, write-first read
//
// Purpose : frame storage. One access per clock; the read register always
//           reflects the addressed word, and on a write it takes the new data.
// Ports   : i_clk   clock
//           i_we    write enable
//           i_addr  word address
//           i_wdata write data
//           o_rdata registered read data
// Contents are never reset.

module pixel_mem_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_DEPTH_LOG2 = 16
) (
  input  logic                      i_clk,
  input  logic                      i_we,
  input  logic [MEM_DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(2**MEM_DEPTH_LOG2)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
      o_rdata       <= i_wdata;
    end else begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/avs_pixel_memory.sv
// rtl/avs_pixel_memory.sv - Avalon-MM slave frame memory with programmable wait states
//
// Purpose : byte-wide image RAM for the accelerator's Avalon-MM master, with
//           waitrequest-based wait states and protocol/address error counting.
// Ports   : csi_clock_clk    clock
//           csi_clock_reset  asynchronous active-high reset
//           avs_address      byte address
//           avs_read         read request
//           avs_write        write request
//           avs_writedata    write data
//           avs_readdata     read data, valid in the acknowledge cycle, held after
//           avs_waitrequest  stall; transfer completes when request high and this low
//           err_count        saturating protocol/address error count
// Options : PIXEL_MEM_RANDOM_WAIT_EN adds 0-3 LFSR-chosen wait cycles per
//           transfer and removes the zero-wait write path.

module avs_pixel_memory
  import pixel_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MEM_DEPTH_LOG2 = 16,
  parameter int READ_WAIT      = DEF_READ_WAIT,
  parameter int WRITE_WAIT     = DEF_WRITE_WAIT
) (
  input  logic                     csi_clock_clk,
  input  logic                     csi_clock_reset,
  input  logic [ADDRESS_WIDTH-1:0] avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [DATA_WIDTH-1:0]    avs_writedata,
  output logic [DATA_WIDTH-1:0]    avs_readdata,
  output logic                     avs_waitrequest,
  output logic [7:0]               err_count
);

  // Counter preload is (wait states - 1): the IDLE accept cycle is itself the
  // first stalled cycle. Writes are floored at one wait state here; the
  // zero-wait case never reaches the counter.
  localparam logic [CNT_W-1:0] RD_BASE = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_BASE = (WRITE_WAIT == 0) ? '0 : CNT_W'(WRITE_WAIT - 1);

`ifdef PIXEL_MEM_RANDOM_WAIT_EN
  localparam logic ZERO_WAIT_OK = 1'b0;
`else
  localparam logic ZERO_WAIT_OK = (WRITE_WAIT == 0);
`endif

  state_t                    r_state;
  state_t                    w_next_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [CNT_W-1:0]          w_load;
  logic [CNT_W-1:0]          w_extra;
  logic [MEM_DEPTH_LOG2-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic                      r_is_write;
  logic                      r_oor;
  logic [7:0]                r_err;
  logic [DATA_WIDTH-1:0]     r_readdata;

  logic                      w_req;
  logic                      w_addr_oor;
  logic                      w_zero_wr;
  logic                      w_accept;
  logic                      w_still_req;
  logic                      w_err_event;
  logic                      w_we_raw;
  logic                      w_ram_we;
  logic [MEM_DEPTH_LOG2-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0]     w_ram_wdata;
  logic [DATA_WIDTH-1:0]     w_ram_q;

  assign w_req       = avs_read | avs_write;
  assign w_addr_oor  = |avs_address[ADDRESS_WIDTH-1:MEM_DEPTH_LOG2];
  assign w_zero_wr   = ZERO_WAIT_OK && (r_state == IDLE) && avs_write && !avs_read;
  assign w_accept    = (r_state == IDLE) && w_req && !w_zero_wr;
  // The master must hold the same request type through the wait states.
  assign w_still_req = r_is_write ? avs_write : avs_read;

`ifdef PIXEL_MEM_RANDOM_WAIT_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
    if (csi_clock_reset) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_accept) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign w_extra = {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
  assign w_extra = '0;
`endif

  // A simultaneous read+write is serviced as a read.
  assign w_load = (avs_read ? RD_BASE : WR_BASE) + w_extra;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_err_event  = 1'b0;
    w_we_raw     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_cnt_next   = w_load;
          w_next_state = (w_load == '0) ? ACK : WAIT;
          w_err_event  = w_addr_oor || (avs_read && avs_write);
        end else if (w_zero_wr) begin
          w_we_raw    = !w_addr_oor;
          w_err_event = w_addr_oor;
        end
      end
      WAIT: begin
        if (!w_still_req) begin
          w_next_state = IDLE;
          w_cnt_next   = '0;
          w_err_event  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_next_state = ACK;
          end
        end
      end
      ACK: begin
        w_next_state = IDLE;
        w_we_raw     = r_is_write && !r_oor;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // No RAM write may slip through while reset holds the FSM in IDLE.
  assign w_ram_we    = w_we_raw && !csi_clock_reset;
  // IDLE presents the live bus so the read is issued on the accept edge;
  // afterwards the latched address keeps the RAM output register stable.
  assign w_ram_addr  = (r_state == IDLE) ? avs_address[MEM_DEPTH_LOG2-1:0] : r_addr;
  assign w_ram_wdata = (r_state == IDLE) ? avs_writedata : r_wdata;

  pixel_mem_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_DEPTH_LOG2 (MEM_DEPTH_LOG2)
  ) u_ram (
    .i_clk   (csi_clock_clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge csi_clock_clk or posedge csi_clock_reset) begin
    if (csi_clock_reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_oor      <= 1'b0;
      r_err      <= '0;
      r_readdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr     <= avs_address[MEM_DEPTH_LOG2-1:0];
        r_wdata    <= avs_writedata;
        r_is_write <= !avs_read;
        r_oor      <= w_addr_oor;
      end
      if (w_err_event && (r_err != ERR_MAX)) begin
        r_err <= r_err + 8'd1;
      end
      if ((r_state == ACK) && !r_is_write) begin
        r_readdata <= r_oor ? '0 : w_ram_q;
      end
    end
  end

  // Read data goes straight from the RAM register in ACK and is held after.
  assign avs_readdata    = ((r_state == ACK) && !r_is_write) ? (r_oor ? '0 : w_ram_q) : r_readdata;
  assign avs_waitrequest = csi_clock_reset | (w_req & !((r_state == ACK) | w_zero_wr));
  assign err_count       = r_err;

endmodule

// File: tb/tb_avs_pixel_memory.sv
// tb/tb_avs_pixel_memory.sv - self-checking bench for avs_pixel_memory

module tb_avs_pixel_memory;

`ifdef PIXEL_MEM_RANDOM_WAIT_EN
  localparam int SLACK = 3;
`else
  localparam int SLACK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] a_addr  = '0;
  logic        a_read  = 1'b0;
  logic        a_write = 1'b0;
  logic [7:0]  a_wdata = '0;
  logic [7:0]  a_rdata;
  logic        a_wait;
  logic [7:0]  a_err;

  logic [31:0] b_addr  = '0;
  logic        b_read  = 1'b0;
  logic        b_write = 1'b0;
  logic [7:0]  b_wdata = '0;
  logic [7:0]  b_rdata;
  logic        b_wait;
  logic [7:0]  b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avs_pixel_memory #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(32), .MEM_DEPTH_LOG2(16), .READ_WAIT(2), .WRITE_WAIT(1)
  ) dut (
    .csi_clock_clk   (clk),
    .csi_clock_reset (rst),
    .avs_address     (a_addr),
    .avs_read        (a_read),
    .avs_write       (a_write),
    .avs_writedata   (a_wdata),
    .avs_readdata    (a_rdata),
    .avs_waitrequest (a_wait),
    .err_count       (a_err)
  );

  avs_pixel_memory #(
    .DATA_WIDTH(8), .ADDRESS_WIDTH(32), .MEM_DEPTH_LOG2(16), .READ_WAIT(1), .WRITE_WAIT(0)
  ) dut0 (
    .csi_clock_clk   (clk),
    .csi_clock_reset (rst),
    .avs_address     (b_addr),
    .avs_read        (b_read),
    .avs_write       (b_write),
    .avs_writedata   (b_wdata),
    .avs_readdata    (b_rdata),
    .avs_waitrequest (b_wait),
    .err_count       (b_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
    int          exp_waits;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_waits(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d wait cycles expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input bit sel, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [7:0] wd, output int waits, output logic [7:0] rdv);
    bit done;
    logic w;
    done  = 1'b0;
    waits = 0;
    rdv   = '0;
    if (sel) begin b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; end
    else     begin a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; end
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      w = sel ? b_wait : a_wait;
      if (!w) begin
        rdv  = sel ? b_rdata : a_rdata;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL xfer_timeout: got no acknowledge expected one within 40 cycles");
    end
    @(posedge clk);
    #1;
    if (sel) begin b_read = 1'b0; b_write = 1'b0; end
    else     begin a_read = 1'b0; a_write = 1'b0; end
  endtask

  initial begin
    int         waits;
    logic [7:0] rdv;

    //             rd    wr    addr           wdata  exp_rd  waits err
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 8'h5A, 8'h00, 1, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0100, 8'h00, 8'h5A, 2, 8'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0010, 8'hAA, 8'h00, 1, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hAA, 2, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 8'h3C, 8'h00, 1, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0001_0000, 8'h00, 8'h00, 2, 8'd1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h3C, 2, 8'd1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0010, 8'h55, 8'hAA, 2, 8'd2};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0010, 8'h00, 8'hAA, 2, 8'd2};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0020, 8'h44, 8'h00, 1, 8'd2};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0020, 8'h00, 8'h44, 2, 8'd2};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_FFFF, 8'hC3, 8'h00, 1, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_FFFF, 8'h00, 8'hC3, 2, 8'd2};
    vecs[13] = '{1'b0, 1'b1, 32'h0001_FFFF, 8'h99, 8'h00, 1, 8'd3};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_FFFF, 8'h00, 8'hC3, 2, 8'd3};
    vecs[15] = '{1'b0, 1'b1, 32'h8000_0000, 8'h12, 8'h00, 1, 8'd4};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 8'h3C, 2, 8'd4};

    // Reset: waitrequest forced high, then outputs at reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wait_in_reset", {31'b0, a_wait}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("wait_after_reset", {31'b0, a_wait}, 32'd0);
    chk("rdata_after_reset", {24'b0, a_rdata}, 32'h00);
    chk("err_after_reset", {24'b0, a_err}, 32'h00);
    @(posedge clk);
    #1;

    // Table of back-to-back transfers on the READ_WAIT=2 / WRITE_WAIT=1 instance.
    foreach (vecs[i]) begin
      xfer(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, waits, rdv);
      chk_waits($sformatf("vec%0d_waits", i), waits, vecs[i].exp_waits, vecs[i].exp_waits + SLACK);
      if (vecs[i].rd) chk($sformatf("vec%0d_rdata", i), {24'b0, rdv}, {24'b0, vecs[i].exp_rd});
      chk($sformatf("vec%0d_err", i), {24'b0, a_err}, {24'b0, vecs[i].exp_err});
    end

    // Read data is held once the bus goes idle.
    @(negedge clk);
    chk("rdata_hold", {24'b0, a_rdata}, 32'h3C);
    @(posedge clk);
    #1;

    // Read dropped during WAIT: aborted and counted.
    a_read = 1'b1;
    a_addr = 32'h0000_0100;
    @(posedge clk);
    #1 a_read = 1'b0;
    @(posedge clk);
    #1;
    chk("err_dropped_req", {24'b0, a_err}, 32'd5);
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0100, 8'h00, waits, rdv);
    chk_waits("after_drop_waits", waits, 2, 2 + SLACK);
    chk("after_drop_rdata", {24'b0, rdv}, 32'h5A);

`ifndef PIXEL_MEM_RANDOM_WAIT_EN
    // Zero-wait writes on consecutive cycles, then readback.
    for (int i = 0; i < 3; i++) begin
      b_write = 1'b1;
      b_addr  = i;
      b_wdata = 8'(8'h11 * (i + 1));
      @(negedge clk);
      chk($sformatf("zw_wait%0d", i), {31'b0, b_wait}, 32'd0);
      @(posedge clk);
      #1;
    end
    b_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 1'b1, 1'b0, i, 8'h00, waits, rdv);
      chk_waits($sformatf("zw_rd%0d_waits", i), waits, 1, 1);
      chk($sformatf("zw_rd%0d_data", i), {24'b0, rdv}, 32'(8'h11 * (i + 1)));
    end
    chk("zw_err", {24'b0, b_err}, 32'd0);
`else
    // Random traffic against a scoreboard.
    begin
      logic [7:0] sb [64];
      logic [7:0] v;
      int         a;
      for (int i = 0; i < 64; i++) begin
        v = 8'($urandom);
        sb[i] = v;
        xfer(1'b0, 1'b0, 1'b1, 32'h40 + i, v, waits, rdv);
        chk_waits("rnd_init_waits", waits, 1, 4);
      end
      for (int n = 0; n < 1000; n++) begin
        a = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) begin
          v = 8'($urandom);
          sb[a] = v;
          xfer(1'b0, 1'b0, 1'b1, 32'h40 + a, v, waits, rdv);
          chk_waits("rnd_wr_waits", waits, 1, 4);
        end else begin
          xfer(1'b0, 1'b1, 1'b0, 32'h40 + a, 8'h00, waits, rdv);
          chk_waits("rnd_rd_waits", waits, 2, 5);
          chk("rnd_rd_data", {24'b0, rdv}, {24'b0, sb[a]});
        end
      end
    end
`endif

    // Reset while a write of 0x77 to 0x20 is stalled: no RAM update.
    a_write = 1'b1;
    a_addr  = 32'h0000_0020;
    a_wdata = 8'h77;
    @(negedge clk);
    chk("midwr_stalled", {31'b0, a_wait}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midwr_wait_in_reset", {31'b0, a_wait}, 32'd1);
    a_write = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midwr_err", {24'b0, a_err}, 32'd0);
    chk("midwr_rdata", {24'b0, a_rdata}, 32'h00);
    @(posedge clk);
    #1;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0020, 8'h00, waits, rdv);
    chk_waits("midwr_rd_waits", waits, 2, 2 + SLACK);
    chk("midwr_kept", {24'b0, rdv}, 32'h44);

    // Error counter saturates.
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, 1'b1, 1'b0, 32'h0004_0000, 8'h00, waits, rdv);
    end
    chk("err_saturate", {24'b0, a_err}, 32'hFF);
    chk("oor_rdata_zero", {24'b0, rdv}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
